uart_rx_param: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 RX path of the UART/BCD top. Adds:
- configurable data width and oversampling;
- four switch-selectable baud rates;
- optional even/odd parity;
- framing, parity and overrun detection;
- a valid/ready output handshake, so the display or TX logic can consume bytes at its own pace.
Sits between the board RX pin and the display/loopback logic, clocked by the 50 MHz board clock.

---
 rtl/uart_rx_param.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Parametrised oversampling UART receiver. It supports 5..9 data
//             bits sent LSB first, four selectable baud rates, and optional
//             even or odd parity. It detects framing, parity and overrun
//             errors. Received words are handed out through a valid/ready
//             output handshake.
//  Options  : define UART_RX_MAJORITY_EN to take each bit decision as the
//             2-of-3 majority of the samples around the mid-bit point
//             (decision one tick later). When undefined, each bit is decided
//             from a single mid-bit sample.
//  Ports    : src_clk    - system clock, rising edge
//             rst        - asynchronous active-high reset
//             rx         - serial input, idle high, asynchronous
//             baud_sel   - tick divider select (DIV0..DIV3), latched per frame
//             parity_en  - parity bit expected after data, latched per frame
//             parity_odd - 1 = odd parity, 0 = even, latched per frame
//             rx_data    - received word, stable while rx_valid
//             rx_valid   - rx_data / frame_err / parity_err valid
//             rx_ready   - consumer accepts word when rx_valid & rx_ready
//             frame_err  - stop bit sampled low (qualified by rx_valid)
//             parity_err - parity mismatch (qualified by rx_valid)
//             overrun    - sticky: a completed frame was dropped
//             clr_err    - one-cycle pulse clears overrun
//             busy       - receiver is inside a frame
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV0       = 326,
    parameter int DIV1       = 54,
    parameter int DIV2       = 27,
    parameter int DIV3       = 14
) (
    input  logic                 src_clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [1:0]           baud_sel,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clr_err,
    output logic                 busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DIV_MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int c_DIV_MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int c_DIV_MAX   = (c_DIV_MAX01 > c_DIV_MAX23) ? c_DIV_MAX01 : c_DIV_MAX23;
    localparam int c_DIV_W     = $clog2(c_DIV_MAX + 1);
    localparam int c_SMP_W     = $clog2(OVERSAMPLE);
    localparam int c_IDX_W     = $clog2(DATA_BITS);

    localparam logic [c_SMP_W-1:0] c_SMP_LAST = c_SMP_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    // Start check is decided one tick after mid start bit, so every later
    // decision (one bit period apart) also lands one tick after its mid-bit.
    localparam logic [c_SMP_W-1:0] c_SMP_START = c_SMP_W'(OVERSAMPLE / 2);
`else
    localparam logic [c_SMP_W-1:0] c_SMP_START = c_SMP_W'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    function automatic logic [c_DIV_W-1:0] f_div_m1(input logic [1:0] sel);
        case (sel)
            2'd0:    f_div_m1 = c_DIV_W'(DIV0 - 1);
            2'd1:    f_div_m1 = c_DIV_W'(DIV1 - 1);
            2'd2:    f_div_m1 = c_DIV_W'(DIV2 - 1);
            default: f_div_m1 = c_DIV_W'(DIV3 - 1);
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_armed;
    logic [c_DIV_W-1:0]   r_tick_cnt;
    logic [c_SMP_W-1:0]   r_smp_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_data_sh;
    logic [1:0]           r_sel;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_perr;
    logic                 r_dlv;
    logic                 r_dlv_ferr;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_mid_start;
    logic                 w_mid_bit;
    logic                 w_start_det;
    logic                 w_bit;
    logic                 w_accept;

    // ------------------------------------------------------------------------
    // Input synchronizer (idle-high reset so no false start after reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Tick / sample strobes
    // ------------------------------------------------------------------------
    assign w_tick      = (r_state != c_ST_IDLE) && (r_tick_cnt == '0);
    assign w_mid_start = w_tick && (r_smp_cnt == c_SMP_START);
    assign w_mid_bit   = w_tick && (r_smp_cnt == c_SMP_LAST);
    assign w_start_det = (r_state == c_ST_IDLE) && r_armed && !r_rx_s;

`ifdef UART_RX_MAJORITY_EN
    // Samples from the two previous ticks; combined with the current rx_s at
    // the decision tick they give the M-1, M, M+1 triplet.
    logic [1:0] r_hist;

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (w_tick) begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_det) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_mid_start) begin
                    w_state_nxt = w_bit ? c_ST_IDLE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_mid_bit && (r_bit_idx == c_IDX_LAST)) begin
                    w_state_nxt = r_par_en ? c_ST_PARITY : c_ST_STOP;
                end
            end
            c_ST_PARITY: begin
                if (w_mid_bit) begin
                    w_state_nxt = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                // Back to IDLE at mid stop bit so a following start edge
                // is caught without waiting for the end of the stop bit.
                if (w_mid_bit) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame datapath: counters, shift register, error capture
    // ------------------------------------------------------------------------
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            r_armed    <= 1'b1;
            r_tick_cnt <= '0;
            r_smp_cnt  <= '0;
            r_bit_idx  <= '0;
            r_data_sh  <= '0;
            r_sel      <= 2'd0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_perr     <= 1'b0;
            r_dlv      <= 1'b0;
            r_dlv_ferr <= 1'b0;
        end else begin
            r_dlv <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (r_rx_s) begin
                    r_armed <= 1'b1;
                end
                if (w_start_det) begin
                    r_tick_cnt <= f_div_m1(baud_sel);
                    r_smp_cnt  <= '0;
                    r_bit_idx  <= '0;
                    r_sel      <= baud_sel;
                    r_par_en   <= parity_en;
                    r_par_odd  <= parity_odd;
                    r_perr     <= 1'b0;
                end
            end else begin
                if (w_tick) begin
                    r_tick_cnt <= f_div_m1(r_sel);
                    r_smp_cnt  <= (r_smp_cnt == c_SMP_LAST) ? '0 : r_smp_cnt + c_SMP_W'(1);
                end else begin
                    r_tick_cnt <= r_tick_cnt - c_DIV_W'(1);
                end

                case (r_state)
                    c_ST_START: begin
                        // Re-phase the sample counter to the mid start bit.
                        if (w_mid_start) begin
                            r_smp_cnt <= '0;
                        end
                    end
                    c_ST_DATA: begin
                        if (w_mid_bit) begin
                            r_data_sh[r_bit_idx] <= w_bit;
                            r_bit_idx            <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                    c_ST_PARITY: begin
                        if (w_mid_bit) begin
                            r_perr <= (^r_data_sh) ^ w_bit ^ r_par_odd;
                        end
                    end
                    c_ST_STOP: begin
                        if (w_mid_bit) begin
                            r_dlv      <= 1'b1;
                            r_dlv_ferr <= ~w_bit;
                            // A low stop bit may be a break: wait for the line
                            // to go high before accepting another start.
                            if (!w_bit) begin
                                r_armed <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------------
    assign w_accept = r_dlv && (!r_rx_valid || rx_ready);

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rx_data    <= r_data_sh;
                r_frame_err  <= r_dlv_ferr;
                r_parity_err <= r_perr;
                r_rx_valid   <= 1'b1;
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            // Set has priority over clear.
            if (r_dlv && !w_accept) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_param
//  Purpose  : Self-checking bench for uart_rx_param. Frames are built at the
//             bit level; the expected word and flags of each frame are queued
//             and matched against every word the receiver hands out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_OS   = 16;
    localparam int c_DIV0 = 40;
    localparam int c_DIV1 = 16;
    localparam int c_DIV2 = 8;
    localparam int c_DIV3 = 5;

    logic       src_clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [1:0] baud_sel;
    logic       parity_en;
    logic       parity_odd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       clr_err;
    logic       busy;

    uart_rx_param #(
        .DATA_BITS (8),
        .OVERSAMPLE(c_OS),
        .DIV0      (c_DIV0),
        .DIV1      (c_DIV1),
        .DIV2      (c_DIV2),
        .DIV3      (c_DIV3)
    ) u_dut (
        .src_clk   (src_clk),
        .rst       (rst),
        .rx        (rx),
        .baud_sel  (baud_sel),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    always #10 src_clk = ~src_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];          // {frame_err, parity_err, data}
    logic [7:0] last_data  = 8'h00;
    logic       last_fe    = 1'b0;
    logic       last_pe    = 1'b0;
    int         n_loaded   = 0;
    bit         auto_ready = 1'b0;
    bit         forced_ready = 1'b1;
    logic       exp_ovr    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bit_clks(input logic [1:0] sel);
        case (sel)
            2'd0:    bit_clks = c_DIV0 * c_OS;
            2'd1:    bit_clks = c_DIV1 * c_OS;
            2'd2:    bit_clks = c_DIV2 * c_OS;
            default: bit_clks = c_DIV3 * c_OS;
        endcase
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge src_clk);
    endtask

    // Sends one frame using the configuration present at its start. When
    // scramble is set the configuration inputs are randomised after the start
    // bit, which must not affect this frame.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                              input bit push, input bit scramble);
        int         bc;
        logic       pen;
        logic       podd;
        logic [9:0] e;
        bc   = bit_clks(baud_sel);
        pen  = parity_en;
        podd = parity_odd;
        if (push) begin
            e[7:0] = d;
            e[8]   = pen & ((^d) ^ pbit ^ podd);
            e[9]   = ~stopb;
            exp_q.push_back(e);
        end
        drive_bit(1'b0, bc);
        if (scramble) begin
            baud_sel   = 2'($urandom_range(0, 3));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
        if (pen) drive_bit(pbit, bc);
        drive_bit(stopb, bc);
        check("word_delivered_by_end_of_stop", 32'(exp_q.size()), 32'd0);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("overrun_after_frame", 32'(overrun), 32'(exp_ovr));
    endtask

    // Consumer: random back-pressure or a forced level.
    initial begin
        rx_ready = 1'b1;
        forever begin
            @(negedge src_clk);
            rx_ready = auto_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Compare process: every word the DUT loads is matched against the queue;
    // a word held under back-pressure must not change.
    initial begin : p_compare
        logic       pv;
        logic [9:0] pw;
        logic [9:0] e;
        pv = 1'b0;
        pw = '0;
        forever begin
            @(posedge src_clk);
            #1;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (rx_valid && (!pv || rx_ready)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got data %0h fe %0b pe %0b, expected no word (t=%0t)",
                                 rx_data, frame_err, parity_err, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_fe_pe_data", 32'({frame_err, parity_err, rx_data}), 32'(e));
                    end
                    last_data = rx_data;
                    last_fe   = frame_err;
                    last_pe   = parity_err;
                    n_loaded++;
                end else if (pv && !rx_ready) begin
                    check("valid_held_without_ready", 32'(rx_valid), 32'd1);
                    check("word_stable_while_held", 32'({frame_err, parity_err, rx_data}), 32'(pw));
                end
                pv = rx_valid;
                pw = {frame_err, parity_err, rx_data};
            end
        end
    end

    // Watchdog
    initial begin
        #(4_000_000);
        n_errors++;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int bc;
        int n0;
        rst        = 1'b1;
        rx         = 1'b1;
        baud_sel   = 2'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        clr_err    = 1'b0;
        repeat (3) @(negedge src_clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge src_clk);

        // 1: slowest rate, 8N1
        forced_ready = 1'b1;
        send_frame(8'h52, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1_count", 32'(n_loaded), 32'd1);
        check("t1_data", 32'(last_data), 32'h52);
        check("t1_fe", 32'(last_fe), 32'd0);
        check("t1_pe", 32'(last_pe), 32'd0);

        // 2: even parity good and bad, then odd parity
        baud_sel = 2'd2; parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t2_even_ok_pe", 32'(last_pe), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t2_even_bad_pe", 32'(last_pe), 32'd1);
        check("t2_even_bad_data", 32'(last_data), 32'h5A);
        parity_odd = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t2_odd_ok_pe", 32'(last_pe), 32'd0);

        // 3: framing error followed by a held-low line (break)
        baud_sel = 2'd3; parity_en = 1'b0; parity_odd = 1'b0;
        bc = bit_clks(2'd3);
        send_frame(8'h41, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_fe", 32'(last_fe), 32'd1);
        check("t3_data", 32'(last_data), 32'h41);
        n0 = n_loaded;
        drive_bit(1'b0, 20 * bc);
        check("t3_no_word_during_break", 32'(n_loaded), 32'(n0));
        check("t3_idle_during_break", 32'(busy), 32'd0);
        drive_bit(1'b1, 2 * bc);
        send_frame(8'h42, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_next_data", 32'(last_data), 32'h42);
        check("t3_next_fe", 32'(last_fe), 32'd0);

        // 4: short low glitch is a false start
        baud_sel = 2'd0;
        n0 = n_loaded;
        rx = 1'b0;
        repeat (4 * c_DIV0 - 10) @(negedge src_clk);
        check("t4_busy_on_glitch", 32'(busy), 32'd1);
        repeat (10) @(negedge src_clk);
        rx = 1'b1;
        repeat (6 * c_DIV0 + 5) @(negedge src_clk);
        check("t4_busy_cleared", 32'(busy), 32'd0);
        check("t4_no_word", 32'(n_loaded), 32'(n0));
        drive_bit(1'b1, bit_clks(2'd0));

`ifdef UART_RX_MAJORITY_EN
        // 4b: one-clock glitch near a data mid-bit is voted out
        baud_sel = 2'd3;
        bc = bit_clks(2'd3);
        exp_q.push_back({2'b00, 8'h55});
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                rx = 1'b1;
                repeat (bc / 2 + 2) @(negedge src_clk);
                rx = 1'b0;
                @(negedge src_clk);
                rx = 1'b1;
                repeat (bc - bc / 2 - 3) @(negedge src_clk);
            end else begin
                drive_bit(i[0] ? 1'b0 : 1'b1, bc);
            end
        end
        drive_bit(1'b1, bc);
        check("t4b_majority_data", 32'(last_data), 32'h55);
`endif

        // 5: overrun under back-pressure, clear, then drain
        baud_sel = 2'd3;
        forced_ready = 1'b0;
        repeat (4) @(negedge src_clk);
        n0 = n_loaded;
        send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_ovr = 1'b1;
        send_frame(8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_one_word_loaded", 32'(n_loaded), 32'(n0 + 1));
        check("t5_rx_data_kept", 32'(rx_data), 32'h41);
        check("t5_valid_kept", 32'(rx_valid), 32'd1);
        clr_err = 1'b1;
        @(negedge src_clk);
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        check("t5_overrun_cleared", 32'(overrun), 32'd0);
        forced_ready = 1'b1;
        repeat (2) @(negedge src_clk);
        check("t5_valid_dropped", 32'(rx_valid), 32'd0);

        // 6: reset in the middle of a frame
        forced_ready = 1'b0;
        repeat (2) @(negedge src_clk);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);
        bc = bit_clks(2'd3);
        drive_bit(1'b0, bc);
        drive_bit(1'b0, bc);     // 0x52 bit 0
        drive_bit(1'b1, bc);     // bit 1
        drive_bit(1'b0, bc);     // bit 2
        drive_bit(1'b0, bc / 2); // half of bit 3
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge src_clk);
        check("t6_rst_rx_data", 32'(rx_data), 32'd0);
        check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("t6_rst_fe", 32'(frame_err), 32'd0);
        check("t6_rst_pe", 32'(parity_err), 32'd0);
        check("t6_rst_overrun", 32'(overrun), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        forced_ready = 1'b1;
        drive_bit(1'b1, bc);
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t6_data", 32'(last_data), 32'h33);
        check("t6_fe", 32'(last_fe), 32'd0);
        check("t6_pe", 32'(last_pe), 32'd0);

        // 7: randomized frames, back-to-back, random back-pressure
        auto_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            logic [7:0] d;
            logic       pb;
            logic       sb;
            baud_sel   = 2'($urandom_range(1, 3));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 7) != 0);
            bc = bit_clks(baud_sel);
            send_frame(d, pb, sb, 1'b1, 1'b1);
            if (!sb) drive_bit(1'b1, bc);
            else if ($urandom_range(0, 1) == 1) drive_bit(1'b1, 32'($urandom_range(1, 40)));
        end

        repeat (50) @(negedge src_clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_overrun", 32'(overrun), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
